// File: rtl/mult_pkg.sv
// Shared widths, FSM encoding and operand-pair type for the multiplier dispatcher.
package mult_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int SEQ_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO in front of the multiplier dispatcher.
// Pointers carry an extra wrap bit so full and empty can be told apart.
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  op_pair_t push_data,
    input  logic     pop,
    output op_pair_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    op_pair_t       mem [DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult_dispatcher.sv
// Feeds queued operand pairs one at a time to an external sequential multiplier,
// with a WAIT timeout, a held result register and a per-job sequence number.
module mult_dispatcher
    import mult_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_result,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    op_pair_t         in_pair;
    op_pair_t         fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;
    logic             abort;
    logic             accept;

    assign in_pair  = {in_a, in_b};
    assign in_ready = !fifo_full;

    mult_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_pair),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // The first WAIT cycle (wait_cnt == 0) ignores mul_done, which may still be
    // high from the previous job; a done in the last WAIT cycle beats the abort.
    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                mul_start  = 1'b1;
                pop        = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt != '0 && mul_done) begin
                    capture    = 1'b1;
                    next_state = ST_DRAIN;
                end else if (wait_cnt == LAST_CNT) begin
                    abort      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    accept     = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a      <= '0;
            mul_b      <= '0;
            wait_cnt   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_seq    <= '0;
            err        <= 1'b0;
        end else begin
            if (state == ST_IDLE && !fifo_empty) begin
                mul_a <= fifo_head.a;
                mul_b <= fifo_head.b;
            end
            if (state == ST_WAIT && next_state == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                           wait_cnt <= '0;
            if (capture) begin
                out_result <= mul_result;
                out_valid  <= 1'b1;
            end
            if (accept) out_valid <= 1'b0;
            if (accept || abort) out_seq <= out_seq + SEQ_W'(1);
            if (abort) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_dispatcher.sv
// Self-checking bench: a cycle-level job model plus a scripted multiplier,
// with directed scenarios pinned by hand-computed expectations.
module tb_mult_dispatcher;
    import mult_pkg::*;

    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 31;
    localparam int CLK_PERIOD = 10;

    typedef enum int {MODE_NORMAL, MODE_STUCK0, MODE_STALE} mul_mode_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              mul_start;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic              mul_done;
    logic [PROD_W-1:0] mul_result;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_result;
    logic [SEQ_W-1:0]  out_seq;
    logic              err;

    int tests_run = 0;
    int failed    = 0;
    int mdl_tests = 0;
    int mdl_fails = 0;

    mul_mode_t mode;
    int        done_delay;

    logic [7:0] pend[$];
    bit         in_flight, captured, exp_ov, err_exp;
    int         job_a, job_b, job_age, retired;
    int         mul_age = 1000;
    logic [7:0] cur_prod = 8'd0;
    logic [7:0] old_prod = 8'd0;
    int         start_count = 0;
    time        last_start_t = 0;

    mult_dispatcher #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_seq    (out_seq),
        .err        (err)
    );

    always #(CLK_PERIOD/2) clk = ~clk;

    task automatic mcheck(input string name, input int actual, input int expected);
        mdl_tests++;
        if (actual != expected) begin
            mdl_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Mid-cycle: check this cycle's outputs against the job model, drive the
    // multiplier for this cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mcheck("rst_in_ready", int'(in_ready), 1);
            mcheck("rst_mul_start", int'(mul_start), 0);
            mcheck("rst_out_valid", int'(out_valid), 0);
            mcheck("rst_out_seq", int'(out_seq), 0);
            mcheck("rst_err", int'(err), 0);
            pend.delete();
            in_flight = 1'b0;
            captured  = 1'b0;
            exp_ov    = 1'b0;
            err_exp   = 1'b0;
            retired   = 0;
            job_age   = 0;
        end else begin
            mcheck("in_ready", int'(in_ready), (pend.size() < DEPTH) ? 1 : 0);
            mcheck("err", int'(err), int'(err_exp));
            mcheck("out_valid", int'(out_valid), int'(exp_ov));
            if (exp_ov) begin
                mcheck("out_result", int'(out_result), job_a * job_b);
                mcheck("out_seq", int'(out_seq), retired % 16);
            end
            if (in_flight) begin
                mcheck("start_while_busy", int'(mul_start), 0);
                if (!captured) begin
                    mcheck("mul_a_hold", int'(mul_a), job_a);
                    mcheck("mul_b_hold", int'(mul_b), job_b);
                end
            end else if (pend.size() == 0) begin
                mcheck("start_when_empty", int'(mul_start), 0);
            end else if (mul_start) begin
                mcheck("mul_a_issue", int'(mul_a), int'(pend[0][7:4]));
                mcheck("mul_b_issue", int'(mul_b), int'(pend[0][3:0]));
            end
        end

        if (mul_start) begin
            mul_age      = 0;
            old_prod     = cur_prod;
            cur_prod     = 8'(mul_a) * 8'(mul_b);
            start_count++;
            last_start_t = $time;
        end else if (mul_age < 1000) begin
            mul_age++;
        end
        case (mode)
            MODE_STUCK0: begin
                mul_done   = 1'b0;
                mul_result = old_prod;
            end
            MODE_STALE: begin
                mul_done   = 1'b1;
                mul_result = (mul_age >= 2) ? cur_prod : old_prod;
            end
            default: begin
                mul_done   = (mul_age >= done_delay);
                mul_result = (mul_age >= done_delay) ? cur_prod : old_prod;
            end
        endcase

        if (rst_n) begin
            automatic bit can_push = (pend.size() < DEPTH);
            if (in_flight) begin
                if (!captured) begin
                    if (job_age >= 2 && mul_done) begin
                        captured = 1'b1;
                        exp_ov   = 1'b1;
                    end else if (job_age == TIMEOUT) begin
                        err_exp   = 1'b1;
                        retired++;
                        in_flight = 1'b0;
                    end
                end else if (out_ready) begin
                    exp_ov    = 1'b0;
                    captured  = 1'b0;
                    retired++;
                    in_flight = 1'b0;
                end
                job_age++;
            end else if (mul_start && pend.size() > 0) begin
                job_a     = int'(pend[0][7:4]);
                job_b     = int'(pend[0][3:0]);
                void'(pend.pop_front());
                in_flight = 1'b1;
                captured  = 1'b0;
                job_age   = 1;
            end
            if (in_valid && can_push) pend.push_back({in_a, in_b});
        end
    end

    task automatic apply_stimulus(input int a, input int b);
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic recv(input int exp_res, input int exp_seq, input int hold,
                        input string name, output time t_seen);
        bit seen = 1'b0;
        int sc0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        t_seen = $time;
        check_output({name, "_seen"}, int'(seen), 1);
        if (seen) begin
            check_output({name, "_result"}, int'(out_result), exp_res);
            check_output({name, "_seq"}, int'(out_seq), exp_seq);
            sc0 = start_count;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_output({name, "_hold_valid"}, int'(out_valid), 1);
                check_output({name, "_hold_result"}, int'(out_result), exp_res);
            end
            if (hold > 0) check_output({name, "_no_restart"}, start_count, sc0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        automatic int  exp_res [5] = '{6, 25, 0, 63, 1};
        automatic time t_seen;
        automatic bit  seen;
        int sc0;

        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        mode       = MODE_NORMAL;
        done_delay = 6;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_in_ready", int'(in_ready), 1);
        check_output("reset_mul_start", int'(mul_start), 0);
        check_output("reset_mul_a", int'(mul_a), 0);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out_seq", int'(out_seq), 0);
        check_output("reset_err", int'(err), 0);
        rst_n = 1'b1;

        // Single job (3,2): start latency, product 6, seq 0.
        sc0 = start_count;
        apply_stimulus(3, 2);
        @(negedge clk);
        check_output("t1_no_start_yet", int'(mul_start), 0);
        @(negedge clk);
        check_output("t1_start", int'(mul_start), 1);
        check_output("t1_mul_a", int'(mul_a), 3);
        check_output("t1_mul_b", int'(mul_b), 2);
        recv(6, 0, 0, "t1", t_seen);
        check_output("t1_gap", int'((t_seen - last_start_t) / CLK_PERIOD), 7);
        check_output("t1_err", int'(err), 0);
        repeat (5) @(posedge clk);
        #1;
        check_output("t1_one_start", start_count - sc0, 1);

        // Fill the FIFO, reject a push while full, hold the (5,5) result.
        do_reset();
        done_delay = 3;
        sc0 = start_count;
        apply_stimulus(3, 2);
        apply_stimulus(5, 5);
        apply_stimulus(15, 0);
        apply_stimulus(7, 9);
        apply_stimulus(1, 1);
        @(negedge clk);
        check_output("t2_full_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        apply_stimulus(9, 9);
        for (int i = 0; i < 5; i++) begin
            recv(exp_res[i], i, (i == 1) ? 10 : 0, $sformatf("t2_job%0d", i), t_seen);
        end
        repeat (20) @(posedge clk);
        #1;
        check_output("t2_start_count", start_count - sc0, 5);

        // Multiplier never finishes: err after TIMEOUT WAIT cycles, then recover.
        do_reset();
        mode = MODE_STUCK0;
        apply_stimulus(4, 4);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (mul_start) seen = 1'b1;
        end
        check_output("t3_start_seen", int'(seen), 1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            check_output("t3_err_early", int'(err), 0);
            check_output("t3_no_valid", int'(out_valid), 0);
        end
        @(negedge clk);
        check_output("t3_err_at_timeout", int'(err), 1);
        check_output("t3_out_seq_after_abort", int'(out_seq), 1);
        @(posedge clk);
        #1;
        mode       = MODE_NORMAL;
        done_delay = 4;
        apply_stimulus(2, 2);
        recv(4, 1, 0, "t3_next", t_seen);
        check_output("t3_err_sticky", int'(err), 1);

        // done stuck high from the last job; the stale first WAIT cycle is ignored.
        @(posedge clk);
        #1;
        mode = MODE_STALE;
        apply_stimulus(6, 7);
        recv(42, 2, 0, "t4_stale", t_seen);
        check_output("t4_gap", int'((t_seen - last_start_t) / CLK_PERIOD), 3);

        // Reset mid-WAIT with two pairs queued.
        @(posedge clk);
        #1;
        mode       = MODE_NORMAL;
        done_delay = 20;
        apply_stimulus(1, 2);
        apply_stimulus(3, 4);
        apply_stimulus(5, 6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_in_ready", int'(in_ready), 1);
        check_output("t5_mul_start", int'(mul_start), 0);
        check_output("t5_mul_a", int'(mul_a), 0);
        check_output("t5_mul_b", int'(mul_b), 0);
        check_output("t5_out_valid", int'(out_valid), 0);
        check_output("t5_out_result", int'(out_result), 0);
        check_output("t5_out_seq", int'(out_seq), 0);
        check_output("t5_err", int'(err), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sc0 = start_count;
        repeat (40) @(posedge clk);
        #1;
        check_output("t5_no_start_after_reset", start_count - sc0, 0);
        apply_stimulus(2, 5);
        recv(10, 0, 0, "t5_fresh", t_seen);
        check_output("t5_one_start", start_count - sc0, 1);

        repeat (5) @(posedge clk);
        #1;
        tests_run += mdl_tests;
        failed    += mdl_fails;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
